// File: rtl/cache_l1_ctrl.sv
// L1 controller: 2-way set-associative, 2 sets, 2-word lines, write-through,
// no-write-allocate; read misses are refilled from L2 as a two-beat fetch.
module cache_l1_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              busy,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata
);
  localparam int TAG_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WT, S_FILL0, S_FILL1, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              lk_hit_q, lk_hit_d;
  logic              victim_q, victim_d;

  // Storage indexed {set, way} for tags/valid and {set, way, word} for data.
  logic [3:0][TAG_W-1:0]  tag_q, tag_d;
  logic [3:0]             valid_q, valid_d;
  logic [1:0]             lru_q, lru_d;
  logic [7:0][DATA_W-1:0] data_q, data_d;

  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              l2_req_q, l2_req_d;
  logic              l2_we_q, l2_we_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;

  logic [TAG_W-1:0] req_tag;
  logic             req_idx, req_off;
  logic             hit0, hit1, lookup_hit, hit_way, pick_victim;

  assign req_tag     = req_addr_q[ADDR_W-1:2];
  assign req_idx     = req_addr_q[1];
  assign req_off     = req_addr_q[0];
  assign hit0        = valid_q[{req_idx, 1'b0}] && (tag_q[{req_idx, 1'b0}] == req_tag);
  assign hit1        = valid_q[{req_idx, 1'b1}] && (tag_q[{req_idx, 1'b1}] == req_tag);
  assign lookup_hit  = hit0 | hit1;
  assign hit_way     = hit1;
  assign pick_victim = !valid_q[{req_idx, 1'b0}] ? 1'b0 :
                       !valid_q[{req_idx, 1'b1}] ? 1'b1 : lru_q[req_idx];

  // L2 handshake: l2_req is held with stable addr/we/wdata until a cycle in
  // which l2_ack=1 is sampled; that cycle completes one beat (and carries
  // l2_rdata on reads). l2_ack is only looked at in WT/FILL0/FILL1.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    lk_hit_d    = lk_hit_q;
    victim_d    = victim_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    lru_d       = lru_q;
    data_d      = data_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    hit_d       = 1'b0;
    l2_req_d    = l2_req_q;
    l2_we_d     = l2_we_q;
    l2_addr_d   = l2_addr_q;
    l2_wdata_d  = l2_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lk_hit_d = lookup_hit;
        if (req_we_q) begin
          if (lookup_hit) begin
            data_d[{req_idx, hit_way, req_off}] = req_wdata_q;
            lru_d[req_idx]                      = ~hit_way;
          end
          l2_req_d   = 1'b1;
          l2_we_d    = 1'b1;
          l2_addr_d  = req_addr_q;
          l2_wdata_d = req_wdata_q;
          state_d    = S_WT;
        end else if (lookup_hit) begin
          cpu_rdata_d    = data_q[{req_idx, hit_way, req_off}];
          hit_d          = 1'b1;
          cpu_ready_d    = 1'b1;
          lru_d[req_idx] = ~hit_way;
          state_d        = S_IDLE;
        end else begin
          victim_d  = pick_victim;
          l2_req_d  = 1'b1;
          l2_we_d   = 1'b0;
          l2_addr_d = {req_tag, req_idx, 1'b0};
          state_d   = S_FILL0;
        end
      end
      S_WT: begin
        if (l2_ack) begin
          l2_req_d    = 1'b0;
          l2_we_d     = 1'b0;
          cpu_ready_d = 1'b1;
          hit_d       = lk_hit_q;
          state_d     = S_IDLE;
        end
      end
      S_FILL0: begin
        if (l2_ack) begin
          data_d[{req_idx, victim_q, 1'b0}] = l2_rdata;
          l2_addr_d = {req_tag, req_idx, 1'b1};
          state_d   = S_FILL1;
        end
      end
      S_FILL1: begin
        // The line only becomes valid here, so a reset mid-fill leaves no trace.
        if (l2_ack) begin
          data_d[{req_idx, victim_q, 1'b1}] = l2_rdata;
          tag_d[{req_idx, victim_q}]        = req_tag;
          valid_d[{req_idx, victim_q}]      = 1'b1;
          lru_d[req_idx]                    = ~victim_q;
          l2_req_d = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        cpu_rdata_d = data_q[{req_idx, victim_q, req_off}];
        cpu_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || cpu_ready_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      lk_hit_q    <= 1'b0;
      victim_q    <= 1'b0;
      tag_q       <= '0;
      valid_q     <= '0;
      lru_q       <= '0;
      data_q      <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      l2_req_q    <= 1'b0;
      l2_we_q     <= 1'b0;
      l2_addr_q   <= '0;
      l2_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      lk_hit_q    <= lk_hit_d;
      victim_q    <= victim_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
      data_q      <= data_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      l2_req_q    <= l2_req_d;
      l2_we_q     <= l2_we_d;
      l2_addr_q   <= l2_addr_d;
      l2_wdata_q  <= l2_wdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign hit       = hit_q;
  assign busy      = busy_q;
  assign l2_req    = l2_req_q;
  assign l2_we     = l2_we_q;
  assign l2_addr   = l2_addr_q;
  assign l2_wdata  = l2_wdata_q;

endmodule

// File: tb/tb_cache_l1_ctrl.sv
// Bench for cache_l1_ctrl: directed scenarios then random accesses, checked
// against an array-based cache/L2 model and an expected queue of L2 beats.
module tb_cache_l1_ctrl;
  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready, hit, busy;
  logic [15:0] cpu_rdata;
  logic        l2_req, l2_we, l2_ack;
  logic [6:0]  l2_addr;
  logic [15:0] l2_wdata, l2_rdata;

  cache_l1_ctrl #(.DATA_W(16), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .hit(hit), .busy(busy),
    .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_rdata(l2_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cache contents, LRU and backing L2 memory
  logic        m_valid [2][2];
  logic [4:0]  m_tag   [2][2];
  logic [15:0] m_data  [2][2][2];
  logic        m_lru   [2];
  logic [15:0] mem     [128];
  logic [23:0] exp_q[$];  // {we, addr, wdata-or-0} per expected L2 beat

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_access(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                              output logic e_hit, output logic [15:0] e_rd);
    int s, o, w, v;
    logic [6:0] base;
    s = int'(addr[1]);
    o = int'(addr[0]);
    w = -1;
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == addr[6:2]) w = i;
    e_hit = (w >= 0);
    e_rd  = 16'h0;
    if (we) begin
      if (e_hit) begin
        m_data[s][w][o] = wdata;
        m_lru[s] = (w == 0);
      end
      mem[addr] = wdata;
      exp_q.push_back({1'b1, addr, wdata});
    end else if (e_hit) begin
      e_rd = m_data[s][w][o];
      m_lru[s] = (w == 0);
    end else begin
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : int'(m_lru[s]));
      base = {addr[6:1], 1'b0};
      exp_q.push_back({1'b0, base, 16'h0});
      exp_q.push_back({1'b0, base | 7'd1, 16'h0});
      m_data[s][v][0] = mem[base];
      m_data[s][v][1] = mem[base | 7'd1];
      m_tag[s][v]     = addr[6:2];
      m_valid[s][v]   = 1'b1;
      m_lru[s]        = (v == 0);
      e_rd            = m_data[s][v][o];
    end
  endtask

  // Driver: one CPU access, serving L2 beats with a fixed ack delay.
  // Called and returns at a negedge.
  task automatic access(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                        input int dly, input bit poke,
                        output logic got_hit, output logic [15:0] got_rdata);
    logic        e_hit;
    logic [15:0] e_rd;
    logic [23:0] obs_q[$];
    logic [23:0] o, e;
    int cnt, cyc, lat, exp_lat;
    bit done, poke_ok;
    model_access(we, addr, wdata, e_hit, e_rd);
    poke_ok = poke && (we || !e_hit);
    got_hit = 1'bx;
    got_rdata = 16'hx;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we = 1'($urandom); cpu_addr = 7'($urandom); cpu_wdata = 16'($urandom);
    cyc = 1; cnt = 0; done = 0; lat = 0;
    while (!done && cyc < 300) begin
      cpu_req = 1'b0;
      l2_ack = 1'b0;
      chk("busy_during", 32'(busy), 32'd1);
      if (cpu_ready) begin
        done = 1;
        lat = cyc;
        got_hit = hit;
        got_rdata = cpu_rdata;
      end else begin
        if (l2_req) begin
          if (cnt == dly) begin
            l2_ack = 1'b1;
            l2_rdata = l2_we ? 16'($urandom) : mem[l2_addr];
            obs_q.push_back({l2_we, l2_addr, l2_we ? l2_wdata : 16'h0});
            cnt = 0;
          end else cnt++;
        end else begin
          l2_ack = 1'($urandom);
          l2_rdata = 16'($urandom);
        end
        if (poke_ok && cyc == 2) cpu_req = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    l2_ack = 1'b0;
    cpu_req = 1'b0;
    chk("timeout", 32'(done), 32'd1);
    chk("l2_beats", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
      chk("l2_beat", 32'(o), 32'(e));
    end
    chk("hit", 32'(got_hit), 32'(e_hit));
    if (!we) chk("rdata", 32'(got_rdata), 32'(e_rd));
    exp_lat = we ? 3 + dly : (e_hit ? 2 : 5 + 2 * dly);
    chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("l2_req_idle", 32'(l2_req), 32'd0);
    if (poke_ok) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("poke_ignored", 32'(cpu_ready), 32'd0);
      end
    end
  endtask

  initial begin
    logic        h;
    logic [15:0] rd;
    logic        rwe;
    logic [6:0]  raddr;

    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    l2_ack = 1'b0; l2_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[4] = 16'hA000;
    mem[5] = 16'hA001;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_hit",       32'(hit),       32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_l2_req",    32'(l2_req),    32'd0);
    chk("rst_l2_we",     32'(l2_we),     32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_l2_addr",   32'(l2_addr),   32'd0);
    chk("rst_l2_wdata",  32'(l2_wdata),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Cold read miss, then hit on the other word of the line
    access(1'b0, 7'h05, 16'h0, 0, 1'b0, h, rd);
    chk("tp_rd05_hit", 32'(h), 32'd0);
    chk("tp_rd05_data", 32'(rd), 32'h0000A001);
    access(1'b0, 7'h04, 16'h0, 0, 1'b0, h, rd);
    chk("tp_rd04_hit", 32'(h), 32'd1);
    chk("tp_rd04_data", 32'(rd), 32'h0000A000);

    // Write hit with slow ack and a request poked while busy
    access(1'b1, 7'h04, 16'h1234, 3, 1'b1, h, rd);
    chk("tp_wr04_hit", 32'(h), 32'd1);
    access(1'b0, 7'h04, 16'h0, 1, 1'b0, h, rd);
    chk("tp_rd04b_data", 32'(rd), 32'h00001234);

    // LRU eviction in set 0
    access(1'b0, 7'h08, 16'h0, 0, 1'b0, h, rd);
    chk("tp_lru_fill08", 32'(h), 32'd0);
    access(1'b0, 7'h04, 16'h0, 0, 1'b0, h, rd);
    chk("tp_lru_hit04", 32'(h), 32'd1);
    access(1'b0, 7'h0C, 16'h0, 2, 1'b0, h, rd);
    chk("tp_lru_miss0c", 32'(h), 32'd0);
    access(1'b0, 7'h04, 16'h0, 0, 1'b0, h, rd);
    chk("tp_lru_keep04", 32'(h), 32'd1);
    access(1'b0, 7'h08, 16'h0, 0, 1'b0, h, rd);
    chk("tp_lru_evict08", 32'(h), 32'd0);

    // Write miss: no allocation
    access(1'b1, 7'h10, 16'hBEEF, 1, 1'b1, h, rd);
    chk("tp_wmiss_hit", 32'(h), 32'd0);
    access(1'b0, 7'h10, 16'h0, 0, 1'b0, h, rd);
    chk("tp_wmiss_rd_hit", 32'(h), 32'd0);
    chk("tp_wmiss_rd_data", 32'(rd), 32'h0000BEEF);

    // Reset in FILL1 abandons the fill
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h31;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rstfill_beat0_req", 32'(l2_req), 32'd1);
    chk("rstfill_beat0_addr", 32'(l2_addr), 32'h30);
    l2_ack = 1'b1;
    l2_rdata = mem[7'h30];
    @(negedge clk);
    l2_ack = 1'b0;
    chk("rstfill_beat1_addr", 32'(l2_addr), 32'h31);
    #2 reset = 1'b1;
    #1;
    chk("rstfill_l2_req", 32'(l2_req), 32'd0);
    chk("rstfill_busy", 32'(busy), 32'd0);
    chk("rstfill_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    access(1'b0, 7'h31, 16'h0, 1, 1'b0, h, rd);
    chk("rstfill_refill_hit", 32'(h), 32'd0);

    // Random traffic over a small address window to force conflicts
    for (int n = 0; n < 150; n++) begin
      rwe = 1'($urandom_range(0, 1));
      raddr = 7'($urandom_range(0, 31));
      access(rwe, raddr, 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), h, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if the stimulus ever stalls outside the bounded waits
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
